// File: rtl/gmii_tx_pkg.sv
// gmii_tx_pkg: shared types and constants for the GMII transmit framer.
//   tx_state_t - framer state encoding
//   byte constants for preamble/SFD/pad/abort, CRC-32 init and reflected poly
package gmii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    PAYLOAD,
    PAD,
    FCS,
    DROP,
    IFG
  } tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [7:0]  PAD_BYTE      = 8'h00;
  localparam logic [7:0]  ABORT_BYTE    = 8'h00;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;

endpackage

// File: rtl/gmii_if.sv
// gmii_if: GMII transmit bundle (valid, data, error).
//   master - driven by the MAC framer
//   slave  - observed by the PHY side
interface gmii_if;
  logic       valid;
  logic [7:0] data;
  logic       error;

  modport master (output valid, output data, output error);
  modport slave  (input  valid, input  data, input  error);
endinterface

// File: rtl/crc32_byte.sv
// crc32_byte: combinational one-byte step of the reflected Ethernet CRC-32.
//   crc_i  - running CRC before this byte
//   data_i - byte to fold in, LSB first
//   crc_o  - running CRC after this byte
// Also used by the RX FCS checker, so it holds no state.
module crc32_byte
  import gmii_tx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] acc;

  always_comb begin
    acc = crc_i ^ {24'h0, data_i};
    for (int b = 0; b < 8; b++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC_POLY) : (acc >> 1);
    end
    crc_o = acc;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: transmit MAC framer toward a GMII PHY.
//   clk, rst_n            - byte clock, async active-low reset
//   s_valid_i/s_ready_o   - source byte handshake
//   s_data_i/s_last_i     - frame byte, end-of-frame marker
//   s_error_i             - source marks the frame bad
//   gmii_tx_if_o          - registered GMII valid/data/error
//   frame_done_pulse_o    - with the last FCS byte on the wire
//   abort_pulse_o         - with the abort (valid+error) byte on the wire
// Adds preamble/SFD, zero-pads to MIN_PAYLOAD, appends FCS, enforces IFG.
module gmii_tx_framer
  import gmii_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned MIN_PAYLOAD    = 60,
  parameter int unsigned MAX_PAYLOAD    = 1514,
  parameter int unsigned IFG_CYCLES     = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  input  logic [7:0] s_data_i,
  input  logic       s_last_i,
  input  logic       s_error_i,
  gmii_if.master     gmii_tx_if_o,
  output logic       frame_done_pulse_o,
  output logic       abort_pulse_o
);

  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_BYTES - 1);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_PAYLOAD);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;

  // The state names the byte being produced for the next edge; every wire
  // output is registered, so each byte appears one cycle after its decision.
  tx_state_t   state_q;
  logic [15:0] cnt_q;     // preamble / payload byte / FCS index / IFG count
  logic [31:0] crc_q, crc_d;
  logic [7:0]  crc_byte;
  logic [31:0] fcs_w;
  logic [7:0]  fcs_byte;
  logic [15:0] cnt_nxt;
  logic        at_max;
  logic        last_taken;

  logic        tx_valid_q, tx_error_q;
  logic [7:0]  tx_data_q;
  logic        done_q, abort_q;

  assign cnt_nxt  = cnt_q + 16'd1;
  assign at_max   = (cnt_q == MAX_CNT);

  // Refusing the byte once the count sits at MAX_PAYLOAD keeps the count
  // saturated; the abort then fires on that cycle and DROP takes the byte.
  assign s_ready_o  = ((state_q == PAYLOAD) && !at_max) || (state_q == DROP);
  assign last_taken = s_ready_o && s_valid_i && s_last_i;

  assign crc_byte = (state_q == PAD) ? PAD_BYTE : s_data_i;

  crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (crc_byte),
    .crc_o  (crc_d)
  );

  // FCS goes out complemented, least significant byte first.
  assign fcs_w    = ~crc_q;
  assign fcs_byte = fcs_w[{cnt_q[1:0], 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      tx_valid_q <= 1'b0;
      tx_error_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      tx_error_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          crc_q <= CRC_INIT;
          cnt_q <= '0;
          // First source byte stays parked at the source until PAYLOAD.
          if (s_valid_i) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= PREAMBLE_BYTE;
            cnt_q      <= 16'd1;
            state_q    <= (PREAMBLE_BYTES > 1) ? PREAMBLE : SFD;
          end
        end
        PREAMBLE: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= PREAMBLE_BYTE;
          cnt_q      <= cnt_nxt;
          if (cnt_q >= PRE_LAST) state_q <= SFD;
        end
        SFD: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= SFD_BYTE;
          cnt_q      <= '0;
          state_q    <= PAYLOAD;
        end
        PAYLOAD: begin
          if (at_max || !s_valid_i || s_error_i) begin
            tx_valid_q <= 1'b1;
            tx_error_q <= 1'b1;
            tx_data_q  <= ABORT_BYTE;
            abort_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= last_taken ? IFG : DROP;
          end else begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= s_data_i;
            crc_q      <= crc_d;
            cnt_q      <= cnt_nxt;
            if (s_last_i) begin
              if (cnt_nxt < MIN_CNT) begin
                state_q <= PAD;
              end else begin
                cnt_q   <= '0;
                state_q <= FCS;
              end
            end
          end
        end
        PAD: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= PAD_BYTE;
          crc_q      <= crc_d;
          if (cnt_nxt >= MIN_CNT) begin
            cnt_q   <= '0;
            state_q <= FCS;
          end else begin
            cnt_q   <= cnt_nxt;
          end
        end
        FCS: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= fcs_byte;
          cnt_q      <= cnt_nxt;
          if (cnt_q[1:0] == 2'd3) begin
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= IFG;
          end
        end
        DROP: begin
          if (s_valid_i && s_last_i) begin
            cnt_q   <= '0;
            state_q <= IFG;
          end
        end
        IFG: begin
          if (cnt_q >= IFG_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_nxt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gmii_tx_if_o.valid = tx_valid_q;
  assign gmii_tx_if_o.data  = tx_data_q;
  assign gmii_tx_if_o.error = tx_error_q;
  assign frame_done_pulse_o = done_q;
  assign abort_pulse_o      = abort_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: directed bench for gmii_tx_framer.
// dut0 runs with padding disabled (CRC check vector), dut1 with defaults;
// sel steers the shared source onto one of them and the wire log.
module tb_gmii_tx_framer;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic       v;
    logic       e;
    logic [7:0] d;
    logic       dn;
    logic       ab;
    logic       sv;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sel = 1'b0;
  logic       s_valid = 1'b0, s_last = 1'b0, s_error = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       sv0, sv1, rdy0, rdy1, dn0, dn1, ab0, ab1;
  logic       rdy, gv, ge, gdn, gab;
  logic [7:0] gd;

  int n_vec = 0;
  int n_err = 0;
  ent_t lg[$];
  logic rec = 1'b0;

  always #4 clk = ~clk;

  gmii_if if0();
  gmii_if if1();

  assign sv0 = s_valid & ~sel;
  assign sv1 = s_valid & sel;

  gmii_tx_framer #(.MIN_PAYLOAD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(sv0), .s_ready_o(rdy0),
    .s_data_i(s_data), .s_last_i(s_last), .s_error_i(s_error),
    .gmii_tx_if_o(if0), .frame_done_pulse_o(dn0), .abort_pulse_o(ab0));

  gmii_tx_framer dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid_i(sv1), .s_ready_o(rdy1),
    .s_data_i(s_data), .s_last_i(s_last), .s_error_i(s_error),
    .gmii_tx_if_o(if1), .frame_done_pulse_o(dn1), .abort_pulse_o(ab1));

  assign rdy = sel ? rdy1 : rdy0;
  assign gv  = sel ? if1.valid : if0.valid;
  assign ge  = sel ? if1.error : if0.error;
  assign gd  = sel ? if1.data  : if0.data;
  assign gdn = sel ? dn1 : dn0;
  assign gab = sel ? ab1 : ab0;

  // Inputs change at posedge+1, so a negedge sample sees one cycle's
  // inputs and outputs together.
  always @(negedge clk) begin
    if (rec) lg.push_back('{v:gv, e:ge, d:gd, dn:gdn, ab:gab, sv:s_valid});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bq_t mk(input int n, input int base, input int step);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(base + i * step));
    return q;
  endfunction

  function automatic bq_t pre();
    bq_t q;
    for (int i = 0; i < 7; i++) q.push_back(8'h55);
    q.push_back(8'hD5);
    return q;
  endfunction

  // Reference reflected CRC-32 (IEEE 802.3), returned already complemented.
  function automatic logic [31:0] crc_ref(input bq_t q);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (q[i]) begin
      c ^= {24'h0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t framed(input bq_t p, input int minp);
    bq_t e = pre();
    bq_t body = p;
    logic [31:0] c;
    while (body.size() < minp) body.push_back(8'h00);
    c = crc_ref(body);
    foreach (body[i]) e.push_back(body[i]);
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
    return e;
  endfunction

  function automatic bq_t head(input bq_t p, input int n);
    bq_t e = pre();
    for (int i = 0; i < n; i++) e.push_back(p[i]);
    return e;
  endfunction

  function automatic int count_v();
    int n = 0;
    foreach (lg[i]) if (lg[i].v) n++;
    return n;
  endfunction

  function automatic int count_dn();
    int n = 0;
    foreach (lg[i]) if (lg[i].dn) n++;
    return n;
  endfunction

  task automatic drive_frame(input bq_t p, input int err_at, input int gap_at, input int stop_at);
    for (int i = 0; i < p.size(); i++) begin
      int t;
      @(posedge clk); #1;
      if (i == stop_at) return;
      if (i == gap_at) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = p[i];
      s_last  = (i == p.size() - 1);
      s_error = (i == err_at);
      t = 0;
      while (!rdy && t < 3000) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 3000) begin
        chk("drive_timeout", t, 0);
        return;
      end
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
  endtask

  // Finds the next frame at/after start and walks it byte by byte; ends
  // either on the done pulse (FCS) or on the abort byte.
  task automatic check_frame(input string tag, input int start, input bq_t exp,
                             input bit is_abort, output int f, output int last);
    f = -1;
    last = -1;
    for (int j = start; j < lg.size(); j++) if (lg[j].v) begin f = j; break; end
    chk({tag, "_found"}, 32'(f >= 0), 1);
    if (f < 0) return;
    if (f + exp.size() + 2 > lg.size()) begin
      chk({tag, "_len"}, lg.size(), f + exp.size() + 2);
      return;
    end
    for (int k = 0; k < exp.size(); k++)
      chk($sformatf("%s_b%0d", tag, k), {lg[f+k].v, lg[f+k].e, lg[f+k].d}, {2'b10, exp[k]});
    if (is_abort) begin
      last = f + exp.size();
      chk({tag, "_abort"}, {lg[last].v, lg[last].e, lg[last].d, lg[last].ab}, {2'b11, 8'h00, 1'b1});
    end else begin
      last = f + exp.size() - 1;
      chk({tag, "_done"}, lg[last].dn, 1);
    end
    chk({tag, "_after"}, lg[last+1].v, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t p, p2, e;
    int f, l, f2, l2, i0;

    // Reset: outputs cleared without any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_dut0", {if0.valid, if0.error, if0.data, rdy0, dn0, ab0}, 0);
    chk("rst_dut1", {if1.valid, if1.error, if1.data, rdy1, dn1, ab1}, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Check vector "123456789", padding disabled.
    sel = 1'b0;
    lg.delete(); rec = 1'b1;
    p = mk(9, 8'h31, 1);
    drive_frame(p, -1, -1, -1);
    go_idle();
    repeat (25) @(posedge clk);
    e = head(p, 9);
    e.push_back(8'h26); e.push_back(8'h39); e.push_back(8'hF4); e.push_back(8'hCB);
    check_frame("t1", 0, e, 0, f, l);
    i0 = -1;
    for (int j = 0; j < lg.size(); j++) if (lg[j].sv) begin i0 = j; break; end
    chk("t1_latency", f - i0, 1);
    chk("t1_ndone", count_dn(), 1);

    // 14-byte frame padded to 60.
    sel = 1'b1;
    #1 lg.delete();
    p = mk(14, 8'h10, 1);
    drive_frame(p, -1, -1, -1);
    go_idle();
    repeat (90) @(posedge clk);
    check_frame("t2", 0, framed(p, 60), 0, f, l);
    chk("t2_nvalid", count_v(), 72);

    // Back-to-back with s_valid held high across the gap.
    lg.delete();
    p  = mk(14, 8'hC0, 5);
    p2 = mk(60, 8'h03, 3);
    drive_frame(p, -1, -1, -1);
    drive_frame(p2, -1, -1, -1);
    go_idle();
    repeat (90) @(posedge clk);
    check_frame("t3a", 0, framed(p, 60), 0, f, l);
    check_frame("t3b", l + 1, framed(p2, 60), 0, f2, l2);
    chk("t3_gap", f2 - l - 1, 12);

    // Underrun before payload byte 20; rest of frame dropped.
    lg.delete();
    p = mk(40, 8'hA0, 1);
    drive_frame(p, -1, 20, -1);
    go_idle();
    repeat (30) @(posedge clk);
    check_frame("t4", 0, head(p, 20), 1, f, l);
    chk("t4_nvalid", count_v(), 29);
    chk("t4_ndone", count_dn(), 0);

    // Error together with last on byte 64, next frame queued behind it.
    lg.delete();
    p  = mk(64, 8'h40, 7);
    p2 = mk(20, 8'h90, 1);
    drive_frame(p, 63, -1, -1);
    drive_frame(p2, -1, -1, -1);
    go_idle();
    repeat (90) @(posedge clk);
    check_frame("t5", 0, head(p, 63), 1, f, l);
    check_frame("t5n", l + 1, framed(p2, 60), 0, f2, l2);
    chk("t5_gap", f2 - l - 1, 12);
    chk("t5_ndone", count_dn(), 1);

    // Asynchronous reset in the middle of the payload.
    lg.delete();
    p = mk(30, 8'h77, 1);
    drive_frame(p, -1, -1, 10);
    chk("t6_pre_valid", {gv, rdy}, 2'b11);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_async", {gv, ge, rdy, gdn, gab}, 0);
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 lg.delete();
    p = mk(14, 8'h5A, 11);
    drive_frame(p, -1, -1, -1);
    go_idle();
    repeat (90) @(posedge clk);
    check_frame("t6n", 0, framed(p, 60), 0, f, l);

    // Oversize: 1514 bytes sent, abort on the following cycle.
    lg.delete();
    p = mk(1520, 1, 7);
    drive_frame(p, -1, -1, -1);
    go_idle();
    repeat (30) @(posedge clk);
    check_frame("t7", 0, head(p, 1514), 1, f, l);
    chk("t7_ndone", count_dn(), 0);

    rec = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
